// File: rtl/stream_bit_decoder_pkg.sv
// Shared definitions for the stream bit decoder.
//   log2()   : ceiling log2, used to size fill/pop/shift fields
//   status_t : registered status flags carried as one bundle
package stream_bit_decoder_pkg;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic full;
    logic half_full;
    logic ready;
    logic overflow;
    logic underflow;
  } status_t;

endpackage

// File: rtl/stream_bit_decoder_bit_buffer_shifter.sv
// bit_buffer_shifter: combinational logical right barrel shift of the bit buffer.
//   i_data  [BUF_W-1:0] : buffer contents, bit 0 = oldest bit
//   i_shamt [SH_W-1:0]  : number of bits to retire (pop plus any alignment skip)
//   o_data  [BUF_W-1:0] : shifted buffer, zero-filled from the top
module bit_buffer_shifter #(
  parameter int unsigned BUF_W = 32,
  parameter int unsigned SH_W  = 6
) (
  input  logic [BUF_W-1:0] i_data,
  input  logic [SH_W-1:0]  i_shamt,
  output logic [BUF_W-1:0] o_data
);

  logic [BUF_W-1:0] w_stage;

  // One stage per shift-amount bit; stages shifting by >= BUF_W clear the word.
  always_comb begin
    w_stage = i_data;
    for (int unsigned s = 0; s < SH_W; s++) begin
      if (i_shamt[s]) w_stage = w_stage >> (32'd1 << s);
    end
    o_data = w_stage;
  end

endmodule

// File: rtl/stream_bit_decoder.sv
// stream_bit_decoder: packs WIDTH_IN-bit words into a BUF_W-bit buffer and
// exposes the oldest WIDTH_OUT bits LSB-first, retiring 0..WIDTH_OUT per cycle.
// Optional feature macro: STREAM_BIT_DECODER_ALIGN_EN (adds align port and
// a modulo-ALIGN retired-bit counter).
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   push, d   : append word d (bit 0 first) when full==0
//   full      : fill > BUF_W-WIDTH_IN
//   half_full : fill >= BUF_W/2
//   pop       : bits to retire this cycle
//   q         : oldest WIDTH_OUT bits, zero beyond fill
//   ready     : fill >= WIDTH_OUT
//   level     : fill in bits
//   overflow  : sticky, push while full
//   underflow : sticky, invalid pop or align skip beyond fill
//   align     : (ALIGN_EN) skip to the next ALIGN boundary after the pop
module stream_bit_decoder
  import stream_bit_decoder_pkg::*;
#(
  parameter int unsigned WIDTH_OUT   = 8,
  parameter int unsigned WIDTH_IN    = 8,
  parameter int unsigned DEPTH_WORDS = 4,
  parameter int unsigned ALIGN       = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    push,
  input  logic [WIDTH_IN-1:0]                     d,
  output logic                                    full,
  output logic                                    half_full,
  input  logic [log2(WIDTH_OUT):0]                pop,
  output logic [WIDTH_OUT-1:0]                    q,
  output logic                                    ready,
  output logic [log2(WIDTH_IN*DEPTH_WORDS):0]     level,
  output logic                                    overflow,
  output logic                                    underflow
`ifdef STREAM_BIT_DECODER_ALIGN_EN
  ,
  input  logic                                    align
`endif
);

  localparam int unsigned BUF_W          = WIDTH_IN * DEPTH_WORDS;
  localparam int unsigned LOG2_WIDTH_OUT = log2(WIDTH_OUT);
  localparam int unsigned LOG2_BUF_W     = log2(BUF_W);
  localparam int unsigned FW             = LOG2_BUF_W + 1;

  if (BUF_W < WIDTH_OUT + WIDTH_IN || ALIGN > BUF_W || ALIGN == 0 ||
      (ALIGN & (ALIGN - 1)) != 0) begin : g_bad_cfg
    $error("stream_bit_decoder: illegal parameter combination");
  end

  logic [BUF_W-1:0] r_buf;
  logic [FW-1:0]    r_fill;
  status_t          r_st;

  logic [FW-1:0]    w_pop;
  logic             w_pop_ok;
  logic [FW-1:0]    w_shift_pop;
  logic [FW-1:0]    w_fill_pop;
  logic [FW-1:0]    w_shift_aln;
  logic             w_aln_bad;
  logic [FW-1:0]    w_shamt;
  logic [FW-1:0]    w_fill_mid;
  logic             w_push_ok;
  logic [BUF_W-1:0] w_shifted;
  logic [BUF_W-1:0] w_ins;
  logic [BUF_W-1:0] w_buf_next;
  logic [FW-1:0]    w_fill_next;
  status_t          w_st_next;

  assign w_pop       = FW'(pop);
  assign w_pop_ok    = (w_pop <= r_fill) && (w_pop <= FW'(WIDTH_OUT));
  assign w_shift_pop = w_pop_ok ? w_pop : '0;
  assign w_fill_pop  = r_fill - w_shift_pop;

`ifdef STREAM_BIT_DECODER_ALIGN_EN
  localparam logic [FW-1:0] AMASK = FW'(ALIGN - 1);

  logic [FW-1:0] r_cnt;
  logic [FW-1:0] w_cnt_pop;
  logic [FW-1:0] w_skip;

  // The skip is measured from the counter as it stands after this cycle's pop.
  always_comb begin
    w_cnt_pop   = (r_cnt + w_shift_pop) & AMASK;
    w_skip      = (FW'(ALIGN) - w_cnt_pop) & AMASK;
    w_shift_aln = '0;
    w_aln_bad   = 1'b0;
    if (align) begin
      if (w_skip <= w_fill_pop) w_shift_aln = w_skip;
      else                      w_aln_bad   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= (r_cnt + w_shamt) & AMASK;
  end
`else
  assign w_shift_aln = '0;
  assign w_aln_bad   = 1'b0;
`endif

  // Pop and alignment skip collapse into a single shift; both are bounded by
  // the registered fill, so the total never exceeds BUF_W.
  assign w_shamt    = w_shift_pop + w_shift_aln;
  assign w_fill_mid = w_fill_pop - w_shift_aln;

  bit_buffer_shifter #(
    .BUF_W (BUF_W),
    .SH_W  (FW)
  ) u_shifter (
    .i_data  (r_buf),
    .i_shamt (w_shamt),
    .o_data  (w_shifted)
  );

  // Bits at/above fill are always zero, so the new word can be OR-ed in.
  assign w_push_ok = push && !r_st.full;
  assign w_ins     = BUF_W'(d) << w_fill_mid;

  always_comb begin
    w_buf_next            = w_shifted | (w_push_ok ? w_ins : '0);
    w_fill_next           = w_fill_mid + (w_push_ok ? FW'(WIDTH_IN) : '0);
    w_st_next.full        = w_fill_next > FW'(BUF_W - WIDTH_IN);
    w_st_next.half_full   = w_fill_next >= FW'(BUF_W / 2);
    w_st_next.ready       = w_fill_next >= FW'(WIDTH_OUT);
    w_st_next.overflow    = r_st.overflow | (push & r_st.full);
    w_st_next.underflow   = r_st.underflow | ~w_pop_ok | w_aln_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_st   <= '0;
    end else begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;
      r_st   <= w_st_next;
    end
  end

  assign q         = r_buf[WIDTH_OUT-1:0];
  assign level     = r_fill;
  assign full      = r_st.full;
  assign half_full = r_st.half_full;
  assign ready     = r_st.ready;
  assign overflow  = r_st.overflow;
  assign underflow = r_st.underflow;

  logic w_unused;
  assign w_unused = ^{LOG2_WIDTH_OUT[0]};

endmodule

// File: tb/tb_stream_bit_decoder.sv
module tb_stream_bit_decoder;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] d;
  logic       full;
  logic       half_full;
  logic [3:0] pop;
  logic [7:0] q;
  logic       ready;
  logic [5:0] level;
  logic       overflow;
  logic       underflow;
`ifdef STREAM_BIT_DECODER_ALIGN_EN
  logic       align;
`endif

  int n_cmp;
  int n_bad;

  stream_bit_decoder #(
    .WIDTH_OUT   (8),
    .WIDTH_IN    (8),
    .DEPTH_WORDS (4),
    .ALIGN       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .d         (d),
    .full      (full),
    .half_full (half_full),
    .pop       (pop),
    .q         (q),
    .ready     (ready),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef STREAM_BIT_DECODER_ALIGN_EN
    ,
    .align     (align)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0;
    d    = 8'h00;
    pop  = 4'd0;
`ifdef STREAM_BIT_DECODER_ALIGN_EN
    align = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    n_cmp++; if (level !== 6'd0)   begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (q !== 8'h00)      begin n_bad++; $display("FAIL rst_q got %h want 00", q); end
    n_cmp++; if ({full, half_full, ready, overflow, underflow} !== 5'b00000)
      begin n_bad++; $display("FAIL rst_flags got %b want 00000", {full, half_full, ready, overflow, underflow}); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push = 1'b1; d = 8'hAB;
    step();
    push = 1'b0;
    n_cmp++; if (level !== 6'd8)   begin n_bad++; $display("FAIL pp_level got %0d want 8", level); end
    n_cmp++; if (q !== 8'hAB)      begin n_bad++; $display("FAIL pp_q got %h want ab", q); end
    n_cmp++; if (ready !== 1'b1)   begin n_bad++; $display("FAIL pp_ready got %b want 1", ready); end
    pop = 4'd4;
    step();
    pop = 4'd0;
    n_cmp++; if (q !== 8'h0A)      begin n_bad++; $display("FAIL pp_pop_q got %h want 0a", q); end
    n_cmp++; if (level !== 6'd4)   begin n_bad++; $display("FAIL pp_pop_level got %0d want 4", level); end
    n_cmp++; if (ready !== 1'b0)   begin n_bad++; $display("FAIL pp_pop_ready got %b want 0", ready); end
  endtask

  task automatic test_fill_levels();
    logic [5:0] exp_lvl;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; d = 8'(i + 1);
      step();
      exp_lvl = 6'(8 * (i + 1));
      n_cmp++; if (level !== exp_lvl) begin n_bad++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, exp_lvl); end
      n_cmp++; if (half_full !== (i >= 1)) begin n_bad++; $display("FAIL fill_half[%0d] got %b want %b", i, half_full, i >= 1); end
      n_cmp++; if (full !== (i == 3)) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i == 3); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_pre got %b want 0", overflow); end
    d = 8'hEE;
    step();
    push = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf got %b want 1", overflow); end
    n_cmp++; if (level !== 6'd32)   begin n_bad++; $display("FAIL fill_ovf_level got %0d want 32", level); end
    n_cmp++; if (q !== 8'h01)       begin n_bad++; $display("FAIL fill_q got %h want 01", q); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; d = 8'(i + 1);
      step();
    end
    push = 1'b1; d = 8'h77; pop = 4'd8;
    step();
    pop = 4'd0;
    n_cmp++; if (level !== 6'd24)   begin n_bad++; $display("FAIL fpp_level got %0d want 24", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fpp_ovf got %b want 1", overflow); end
    n_cmp++; if (q !== 8'h02)       begin n_bad++; $display("FAIL fpp_q got %h want 02", q); end
    d = 8'h99;
    step();
    push = 1'b0;
    n_cmp++; if (level !== 6'd32)   begin n_bad++; $display("FAIL fpp_retry_level got %0d want 32", level); end
    n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL fpp_retry_full got %b want 1", full); end
    // Drain: remaining words 02,03,04,99 in order.
    pop = 4'd8;
    step();
    n_cmp++; if (q !== 8'h03)       begin n_bad++; $display("FAIL fpp_drain1 got %h want 03", q); end
    step();
    n_cmp++; if (q !== 8'h04)       begin n_bad++; $display("FAIL fpp_drain2 got %h want 04", q); end
    step();
    pop = 4'd0;
    n_cmp++; if (q !== 8'h99)       begin n_bad++; $display("FAIL fpp_drain3 got %h want 99", q); end
    n_cmp++; if (level !== 6'd8)    begin n_bad++; $display("FAIL fpp_drain_level got %0d want 8", level); end
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 4'd0;
    step();
    n_cmp++; if (level !== 6'd0 || underflow !== 1'b0)
      begin n_bad++; $display("FAIL uf_noop got level %0d uf %b want 0 0", level, underflow); end
    push = 1'b1; d = 8'hC5;
    step();
    push = 1'b0; pop = 4'd5;
    step();
    n_cmp++; if (level !== 6'd3)    begin n_bad++; $display("FAIL uf_setup_level got %0d want 3", level); end
    n_cmp++; if (q !== 8'h06)       begin n_bad++; $display("FAIL uf_setup_q got %h want 06", q); end
    step();
    pop = 4'd0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_flag got %b want 1", underflow); end
    n_cmp++; if (level !== 6'd3)    begin n_bad++; $display("FAIL uf_level got %0d want 3", level); end
    pop = 4'd3;
    step();
    pop = 4'd0;
    n_cmp++; if (level !== 6'd0 || q !== 8'h00)
      begin n_bad++; $display("FAIL uf_exact got level %0d q %h want 0 00", level, q); end
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got %b want 1", underflow); end
    do_reset();
    #1;
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_reset got %b want 0", underflow); end
    // pop wider than the window is invalid even with enough bits held.
    push = 1'b1; d = 8'h11;
    step();
    d = 8'h22;
    step();
    push = 1'b0; pop = 4'd9;
    step();
    pop = 4'd0;
    n_cmp++; if (underflow !== 1'b1 || level !== 6'd16)
      begin n_bad++; $display("FAIL uf_wide got uf %b level %0d want 1 16", underflow, level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push = 1'b1; d = 8'hA1;
    step();
    d = 8'hB2; pop = 4'd8;
    step();
    d = 8'hC3; pop = 4'd4;
    step();
    push = 1'b0; pop = 4'd0;
    // After: B2 popped by 4 -> 0x0B in low nibble, C3 lands at bit 4.
    n_cmp++; if (level !== 6'd12)   begin n_bad++; $display("FAIL b2b_level got %0d want 12", level); end
    n_cmp++; if (q !== 8'h3B)       begin n_bad++; $display("FAIL b2b_q got %h want 3b", q); end
  endtask

`ifdef STREAM_BIT_DECODER_ALIGN_EN
  task automatic test_align();
    do_reset();
    push = 1'b1; d = 8'hFF;
    step();
    d = 8'h5A;
    step();
    push = 1'b0; pop = 4'd3;
    step();
    pop = 4'd0; align = 1'b1;
    step();
    n_cmp++; if (level !== 6'd8)    begin n_bad++; $display("FAIL aln_level got %0d want 8", level); end
    n_cmp++; if (q !== 8'h5A)       begin n_bad++; $display("FAIL aln_q got %h want 5a", q); end
    step();
    align = 1'b0;
    n_cmp++; if (level !== 6'd8 || q !== 8'h5A || underflow !== 1'b0)
      begin n_bad++; $display("FAIL aln_noop got level %0d q %h uf %b want 8 5a 0", level, q, underflow); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_push_pop();
    test_fill_levels();
    test_full_push_pop();
    test_underflow();
    test_back_to_back();
`ifdef STREAM_BIT_DECODER_ALIGN_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
